// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: 8-bit unsigned value to three BCD digits, one bit per cycle.
// Optional seven-segment outputs with leading-zero blanking are enabled by defining RESULT_BCD_SEG_EN.
module result_bcd_converter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_hund
`ifdef RESULT_BCD_SEG_EN
    ,
    output logic [6:0] hex_ones,
    output logic [6:0] hex_tens,
    output logic [6:0] hex_hund
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hund_q, hund_d;
    logic [11:0] adj_s;
    logic [11:0] next_scratch_s;

    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

`ifdef RESULT_BCD_SEG_EN
    logic [6:0] hex_ones_q, hex_ones_d;
    logic [6:0] hex_tens_q, hex_tens_d;
    logic [6:0] hex_hund_q, hex_hund_d;

    // Active-low glyphs, bit0 = segment a through bit6 = segment g.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction
`endif

    // Correction step and shift of the scratch register for the current bit.
    always_comb begin
        adj_s          = {add3_digit(scratch_q[11:8]), add3_digit(scratch_q[7:4]),
                          add3_digit(scratch_q[3:0])};
        next_scratch_s = {adj_s[10:0], shift_q[7]};
    end

    // Next-state logic for the conversion FSM and all registered outputs.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ones_d    = ones_q;
        tens_d    = tens_q;
        hund_d    = hund_q;
`ifdef RESULT_BCD_SEG_EN
        hex_ones_d = hex_ones_q;
        hex_tens_d = hex_tens_q;
        hex_hund_d = hex_hund_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = value;
                    scratch_d = 12'd0;
                    cnt_d     = 4'd8;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            CONV: begin
                scratch_d = next_scratch_s;
                shift_d   = {shift_q[6:0], 1'b0};
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    ones_d  = next_scratch_s[3:0];
                    tens_d  = next_scratch_s[7:4];
                    hund_d  = next_scratch_s[11:8];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef RESULT_BCD_SEG_EN
                    hex_ones_d = seg_decode(next_scratch_s[3:0]);
                    hex_tens_d = (next_scratch_s[11:4] == 8'd0) ? 7'b1111111
                                                                : seg_decode(next_scratch_s[7:4]);
                    hex_hund_d = (next_scratch_s[11:8] == 4'd0) ? 7'b1111111
                                                                : seg_decode(next_scratch_s[11:8]);
`endif
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            scratch_q <= 12'd0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            hund_q    <= 4'd0;
`ifdef RESULT_BCD_SEG_EN
            hex_ones_q <= 7'b1000000;
            hex_tens_q <= 7'b1111111;
            hex_hund_q <= 7'b1111111;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
`ifdef RESULT_BCD_SEG_EN
            hex_ones_q <= hex_ones_d;
            hex_tens_q <= hex_tens_d;
            hex_hund_q <= hex_hund_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_ones = ones_q;
    assign bcd_tens = tens_q;
    assign bcd_hund = hund_q;
`ifdef RESULT_BCD_SEG_EN
    assign hex_ones = hex_ones_q;
    assign hex_tens = hex_tens_q;
    assign hex_hund = hex_hund_q;
`endif

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: vector table, corner-case sequences,
// random values and a full 0..255 sweep against an arithmetic reference model.
module tb_result_bcd_converter;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_hund;
`ifdef RESULT_BCD_SEG_EN
    logic [6:0] hex_ones;
    logic [6:0] hex_tens;
    logic [6:0] hex_hund;
`endif

    result_bcd_converter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd_ones (bcd_ones),
        .bcd_tens (bcd_tens),
        .bcd_hund (bcd_hund)
`ifdef RESULT_BCD_SEG_EN
        ,
        .hex_ones (hex_ones),
        .hex_tens (hex_tens),
        .hex_hund (hex_hund)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t tbl [10];
    int   checks   = 0;
    int   failures = 0;
    int   prev_h   = 0;
    int   prev_t   = 0;
    int   prev_o   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

`ifdef RESULT_BCD_SEG_EN
    function automatic logic [6:0] glyph(input int d);
        logic [6:0] g [10];
        g = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return g[d];
    endfunction

    task automatic check_hex(input int h, input int t, input int o);
        check("hex_ones", {25'd0, hex_ones}, {25'd0, glyph(o)});
        check("hex_tens", {25'd0, hex_tens},
              (h == 0 && t == 0) ? 32'h7f : {25'd0, glyph(t)});
        check("hex_hund", {25'd0, hex_hund}, (h == 0) ? 32'h7f : {25'd0, glyph(h)});
    endtask
`endif

    // Start a conversion, follow it cycle by cycle and compare against value/100, /10%10, %10.
    task automatic run_conv(input logic [7:0] v, input bit at_slot);
        int k;
        int eh;
        int et;
        int eo;
        eh = int'(v) / 100;
        et = (int'(v) / 10) % 10;
        eo = int'(v) % 10;
        if (!at_slot) @(negedge clk);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        value = 8'($urandom);
        k = 0;
        while (!done && k < 20) begin
            check("busy_during_conv", {31'd0, busy}, 32'd1);
            check("hund_held", {28'd0, bcd_hund}, prev_h);
            check("tens_held", {28'd0, bcd_tens}, prev_t);
            check("ones_held", {28'd0, bcd_ones}, prev_o);
            @(negedge clk);
            k++;
        end
        check("latency", k, 32'd8);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("bcd_hund", {28'd0, bcd_hund}, eh);
        check("bcd_tens", {28'd0, bcd_tens}, et);
        check("bcd_ones", {28'd0, bcd_ones}, eo);
`ifdef RESULT_BCD_SEG_EN
        check_hex(eh, et, eo);
`endif
        prev_h = eh;
        prev_t = et;
        prev_o = eo;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        tbl[0] = '{8'd255, 4'd2, 4'd5, 4'd5};
        tbl[1] = '{8'd0,   4'd0, 4'd0, 4'd0};
        tbl[2] = '{8'd9,   4'd0, 4'd0, 4'd9};
        tbl[3] = '{8'd100, 4'd1, 4'd0, 4'd0};
        tbl[4] = '{8'd37,  4'd0, 4'd3, 4'd7};
        tbl[5] = '{8'd128, 4'd1, 4'd2, 4'd8};
        tbl[6] = '{8'd99,  4'd0, 4'd9, 4'd9};
        tbl[7] = '{8'd10,  4'd0, 4'd1, 4'd0};
        tbl[8] = '{8'd199, 4'd1, 4'd9, 4'd9};
        tbl[9] = '{8'd200, 4'd2, 4'd0, 4'd0};

        reset = 1'b1;
        start = 1'b0;
        value = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_digits", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'd0);
`ifdef RESULT_BCD_SEG_EN
        check_hex(0, 0, 0);
`endif
        reset = 1'b0;

        // Table vectors with hand-computed expectations.
        for (int i = 0; i < 10; i++) begin
            run_conv(tbl[i].v, 1'b0);
            check("tbl_hund", {28'd0, bcd_hund}, {28'd0, tbl[i].h});
            check("tbl_tens", {28'd0, bcd_tens}, {28'd0, tbl[i].t});
            check("tbl_ones", {28'd0, bcd_ones}, {28'd0, tbl[i].o});
            @(negedge clk);
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("idle_not_busy", {31'd0, busy}, 32'd0);
        end

        // Back-to-back: start held in the done cycle is accepted.
        run_conv(8'd9, 1'b0);
        run_conv(8'd100, 1'b1);
        @(negedge clk);
        check("b2b_done_low", {31'd0, done}, 32'd0);

        // Starts while busy are ignored.
        @(negedge clk);
        start = 1'b1;
        value = 8'd37;
        @(negedge clk);
        start = 1'b0;
        value = 8'd200;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (12) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("ignored_single_done", ndone, 32'd1);
        check("ignored_digits", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'h037);
        check("ignored_idle", {31'd0, busy}, 32'd0);
        prev_h = 0;
        prev_t = 3;
        prev_o = 7;

        // Reset mid-conversion aborts without done.
        @(negedge clk);
        start = 1'b1;
        value = 8'd128;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_digits", {20'd0, bcd_hund, bcd_tens, bcd_ones}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_h = 0;
        prev_t = 0;
        prev_o = 0;
        ndone = 0;
        repeat (12) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", ndone, 32'd0);
        run_conv(8'd128, 1'b0);

        // Random values against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            run_conv(8'($urandom_range(255, 0)), 1'b0);
        end

        // Exhaustive sweep, issued back-to-back.
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), (v != 0));
        end
        @(negedge clk);
        check("sweep_done_low", {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
